// File: rtl/prefetch_pkg.sv
// Shared widths, NOP encoding and the queue entry layout for the instruction prefetch queue.
package prefetch_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;
  localparam logic [PC_W-1:0]    PC_INC    = 64'd4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return addr & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Generic synchronous FIFO with clear: zero-latency head, write visible one cycle after push.
// Caller owns flow control; push when full or pop when empty are ignored.
module prefetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the head is only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/instruction_prefetch_queue.sv
// Credit-based fetch-ahead queue between imem and IF-ID; response to deq_valid is 1 cycle, head holds under !deq_ready.
// Redirect flushes the queue and drops stale responses; PREFETCH_PERF_CNT_EN adds flush/empty counters.
module instruction_prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               deq_valid,
  output logic [INSTR_W-1:0] deq_instr,
  output logic [PC_W-1:0]    deq_pc,
  input  logic               deq_ready
`ifdef PREFETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_flush_cnt,
  output logic [31:0]        perf_empty_cnt
`endif
);

  localparam int CW = $clog2(DEPTH+1);

  logic [PC_W-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   credits;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   pc_count;
  logic [PC_W-1:0] pc_head;
  entry_t          q_head;
  entry_t          q_in;
  logic            req_fire;
  logic            resp_keep;
  logic            deq_fire;
  logic            q_nonempty;

  // Every accepted request reserves a queue slot until its response is consumed or dropped.
  assign credits        = CW'(DEPTH) - q_count - outstanding;
  assign imem_req_valid = rst && !redirect && (credits != '0);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_keep = imem_resp_valid && !redirect && (drop_cnt == '0) && (pc_count != '0);
  assign q_in      = '{pc: pc_head, instr: imem_resp_data};

  assign q_nonempty = (q_count != '0);
  assign deq_valid  = !redirect && q_nonempty;
  assign deq_fire   = deq_valid && deq_ready;
  assign deq_instr  = q_nonempty ? q_head.instr : NOP_INSTR;
  assign deq_pc     = q_nonempty ? q_head.pc : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (redirect)      fetch_pc <= word_align(redirect_pc);
      else if (req_fire) fetch_pc <= fetch_pc + PC_INC;

      case ({req_fire, imem_resp_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      // Everything still in flight at a redirect is stale, including responses already marked for drop.
      if (redirect)
        drop_cnt <= outstanding - CW'(imem_resp_valid);
      else if (imem_resp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);
    end
  end

  prefetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk      (clk),
    .rst      (rst),
    .clear    (redirect),
    .push     (resp_keep),
    .push_dat (q_in),
    .pop      (deq_fire),
    .pop_dat  (q_head),
    .count    (q_count)
  );

  prefetch_fifo #(
    .WIDTH (PC_W),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (redirect),
    .push     (req_fire),
    .push_dat (fetch_pc),
    .pop      (resp_keep),
    .pop_dat  (pc_head),
    .count    (pc_count)
  );

`ifdef PREFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_flush_cnt <= '0;
      perf_empty_cnt <= '0;
    end else begin
      if (redirect && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (deq_ready && !deq_valid && (perf_empty_cnt != '1))
        perf_empty_cnt <= perf_empty_cnt + 32'd1;
    end
  end
`endif

  a_resp_has_request: assert property (@(posedge clk) disable iff (!rst)
    imem_resp_valid |-> (outstanding != '0));

  a_resp_not_full: assert property (@(posedge clk) disable iff (!rst)
    imem_resp_valid |-> (q_count != CW'(DEPTH)));

endmodule

// File: doc/instruction_prefetch_queue.md
# instruction_prefetch_queue

Decoupling buffer between instruction memory and the IF-ID register. Issues sequential fetch requests ahead of the pipeline and tracks outstanding responses. Holds returned instructions with their PCs in an in-order queue, and flushes everything on a taken-branch redirect from the memory stage. Replaces the direct PC→imem→IF-ID path so the fetch side tolerates multi-cycle imem latency and ID stalls.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- RESET_PC, 64'h0, first fetch address after reset
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, asynchronous, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  64  fetch byte address, word aligned
- imem_req_ready  in  1  imem accepts request this cycle
- imem_resp_valid  in  1  response valid; in order, one per accepted request, ≥1 cycle after acceptance
- imem_resp_data  in  32  returned instruction
- redirect  in  1  taken branch (PCSrc)
- redirect_pc  in  64  new fetch address (pc_branch)
- deq_valid  out  1  queue head valid
- deq_instr  out  32  head instruction
- deq_pc  out  64  head PC
- deq_ready  in  1  IF-ID consumes head (ifid_write)

## Operation
- State: fetch_pc, queue (instr, pc) ×DEPTH, count, outstanding, drop_cnt, in-flight PC FIFO (DEPTH entries).
- Credits = DEPTH − count − outstanding.
- imem_req_valid = !redirect && credits > 0.
- imem_req_addr = fetch_pc.
- Request fire (valid && ready): push fetch_pc to the in-flight PC FIFO, fetch_pc += 4 (mod 2^64), outstanding += 1.
- Response:
  - If drop_cnt > 0: discard, drop_cnt −= 1, outstanding −= 1.
  - Otherwise: enqueue (imem_resp_data, popped in-flight PC), outstanding −= 1.
- Credits guarantee no overflow; a response when count == DEPTH is impossible by construction (verify with assertion).
- Dequeue: deq_valid && deq_ready pops head. Head fields are stable while deq_valid && !deq_ready.
- Redirect (level, sampled each edge):
  - deq_valid forced 0 and no request issued this cycle.
  - At the edge: queue and in-flight PC FIFO cleared, fetch_pc ← redirect_pc.
  - drop_cnt ← outstanding − (response this cycle ? 1 : 0), counting the current drop_cnt responses as well. A response arriving in the redirect cycle is discarded.
- Redirect while drop_cnt > 0: accumulates correctly per the rule above; no new enqueue until drop_cnt reaches 0.
- Simultaneous enqueue and dequeue: count unchanged; an empty queue enqueues only (no same-cycle bypass).
- redirect_pc[1:0] is ignored (treated as 0).

## Timing
- Reset values: deq_valid 0, deq_instr 32'h00000013 (NOP), deq_pc 0, fetch_pc RESET_PC, count/outstanding/drop_cnt 0. imem_req_valid is 0 while rst is low.
- First request is visible in the first cycle after rst deasserts.
- Latency from response to deq_valid: 1 cycle. With zero backpressure and 1-cycle imem, throughput is 1 instr/cycle.
- Redirect to first new request: 1 cycle. Redirect to first new deq_valid: imem latency + 1 cycle after that request.
- Reset mid-operation clears all state immediately; responses still in flight from before reset are the integrator's responsibility (imem resets on the same rst).

## Configuration
- PREFETCH_PERF_CNT_EN defined: adds outputs perf_flush_cnt (32) and perf_empty_cnt (32).
  - perf_flush_cnt increments per redirect cycle.
  - perf_empty_cnt increments per cycle with deq_ready high and deq_valid low.
  - Both saturate at all-ones, reset to 0.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- Package prefetch_pkg: PC width 64, instruction width 32, NOP encoding 32'h00000013, PC increment 4.
- One sub-module, prefetch_fifo: parameterised synchronous FIFO (width, depth, push/pop/clear, count). Instantiated twice, for the instruction queue and the in-flight PC FIFO.

## Test plan
- Reset, imem always ready, 1-cycle response, deq_ready=1 → requests at 0x0,0x4,0x8…; deq_pc 0x0 two cycles after reset release, then one per cycle.
- Hold deq_ready=0, DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0. deq_instr stays at the instruction from 0x0. Releasing drains 0x0..0xC in order.
- imem latency 3 with 2 requests outstanding, redirect to 0x100 → both stale responses dropped, next deq_pc=0x100, no 0x8/0xC ever dequeued.
- Redirect coinciding with a response and dequeue → response dropped, no deq handshake, fetch restarts at redirect_pc next cycle.
- Back-to-back redirects (0x40 then 0x80) → no instruction from 0x40 or earlier delivered; first deq_pc=0x80.
- Assert rst low while queue holds 3 entries → deq_valid=0 and deq_instr=0x00000013 immediately; fetch restarts at RESET_PC.
